// File: rtl/dma_word_copy.sv
// Word-granular copy engine: read-then-write one 32-bit word at a time on the
// data-memory port, honouring clk_stall back-pressure with a per-access timeout.
module dma_word_copy #(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [3:0]        mem_sign_mask,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_clk_stall
);
  // state | meaning
  // IDLE  | waiting for start, memory port quiet
  // RD    | read request held on cur_src (first cycle is issue only)
  // WR    | write request held on cur_dst with captured word
  // FIN   | done pulse, busy drops on exit
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state;
  logic [ADDR_W-1:0]  cur_src;
  logic [ADDR_W-1:0]  cur_dst;
  logic [LEN_W-1:0]   remaining;
  logic [CNT_W-1:0]   stall_cnt;
  logic               issue;

  assign mem_sign_mask = 4'b0111;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_addr     <= '0;
      mem_wr_data  <= '0;
      cur_src      <= '0;
      cur_dst      <= '0;
      remaining    <= '0;
      stall_cnt    <= '0;
      issue        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_src   <= src_addr;
            cur_dst   <= dst_addr;
            remaining <= len;
            stall_cnt <= '0;
            error     <= 1'b0;
            busy      <= 1'b1;
            if (src_addr[1:0] != 2'b00 || dst_addr[1:0] != 2'b00) begin
              state <= S_FIN;
              done  <= 1'b1;
              error <= 1'b1;
            end else if (len == '0) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state       <= S_RD;
              issue       <= 1'b1;
              mem_memread <= 1'b1;
              mem_addr    <= src_addr;
            end
          end
        end

        S_RD: begin
          if (issue) begin
            issue <= 1'b0;
          end else if (!mem_clk_stall) begin
            state        <= S_WR;
            issue        <= 1'b1;
            stall_cnt    <= '0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b1;
            mem_addr     <= cur_dst;
            mem_wr_data  <= mem_read_data;
          end else if (stall_cnt == STALL_LAST) begin
            state       <= S_FIN;
            done        <= 1'b1;
            error       <= 1'b1;
            mem_memread <= 1'b0;
            mem_addr    <= '0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end

        S_WR: begin
          if (issue) begin
            issue <= 1'b0;
          end else if (!mem_clk_stall) begin
            cur_src      <= cur_src + ADDR_W'(4);
            cur_dst      <= cur_dst + ADDR_W'(4);
            remaining    <= remaining - 1'b1;
            stall_cnt    <= '0;
            mem_memwrite <= 1'b0;
            mem_wr_data  <= '0;
            if (remaining == LEN_W'(1)) begin
              state    <= S_FIN;
              done     <= 1'b1;
              mem_addr <= '0;
            end else begin
              state       <= S_RD;
              issue       <= 1'b1;
              mem_memread <= 1'b1;
              mem_addr    <= cur_src + ADDR_W'(4);
            end
          end else if (stall_cnt == STALL_LAST) begin
            state        <= S_FIN;
            done         <= 1'b1;
            error        <= 1'b1;
            mem_memwrite <= 1'b0;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end

        S_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_word_copy.sv
// Bench for dma_word_copy: a vector table of copies against a stalling memory
// model, plus hand sequences for timeout, mid-copy reset and start-while-busy.
module tb_dma_word_copy;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len;
  logic        busy, done, error;
  logic [31:0] mem_addr, mem_wr_data, mem_read_data;
  logic        mem_memwrite, mem_memread, mem_clk_stall;
  logic [3:0]  mem_sign_mask;

  dma_word_copy #(.ADDR_W(32), .LEN_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .error(error),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
    .mem_clk_stall(mem_clk_stall)
  );

  always #5 clk = ~clk;

  // Memory model: cycle 0 of a request is issue, then stall_n stall cycles, then completion.
  logic [31:0] mem [0:1023];
  int          cyc = 0;
  int          stall_n = 0;
  bit          stuck = 1'b0;
  int          rd_done = 0, wr_done = 0;
  bit          fill = 1'b0, pk_en = 1'b0;
  logic [9:0]  pk_idx = '0;
  logic [31:0] pk_dat = '0;
  logic [9:0]  midx;

  assign midx          = mem_addr[11:2];
  assign mem_read_data = mem[midx];
  assign mem_clk_stall = stuck || (cyc != 0 && cyc <= stall_n);

  always @(posedge clk) begin
    if (fill) for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
    if (pk_en) mem[pk_idx] <= pk_dat;
    if (mem_memread === 1'b1 || mem_memwrite === 1'b1) begin
      if (cyc != 0 && !mem_clk_stall) begin
        cyc <= 0;
        if (mem_memwrite) begin
          mem[midx] <= mem_wr_data;
          wr_done   <= wr_done + 1;
        end else begin
          rd_done <= rd_done + 1;
        end
      end else begin
        cyc <= cyc + 1;
      end
    end else begin
      cyc <= 0;
    end
  end

  int checks = 0, errors = 0, rd_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    start = 1'b0;
    if (mem_memread === 1'b1) rd_cyc++;
    chk("rw_exclusive", {31'b0, mem_memread & mem_memwrite}, 32'h0);
    chk("sign_mask", {28'b0, mem_sign_mask}, 32'h7);
    if (busy === 1'b0) begin
      chk("idle_req", {30'b0, mem_memread, mem_memwrite}, 32'h0);
      chk("idle_addr", mem_addr, 32'h0);
      chk("idle_wdata", mem_wr_data, 32'h0);
    end
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input int l);
    src_addr = s;
    dst_addr = d;
    len      = 16'(l);
    start    = 1'b1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (done !== 1'b1 && lat < 2000);
    chk("done_seen", {31'b0, done}, 32'h1);
  endtask

  task automatic poke(input logic [9:0] idx, input logic [31:0] dat);
    pk_idx = idx;
    pk_dat = dat;
    pk_en  = 1'b1;
    tick();
    pk_en  = 1'b0;
  endtask

  task automatic run(input string name, input logic [31:0] s, input logic [31:0] d,
                     input int l, input int st, input bit exp_err, input int exp_lat);
    logic [31:0] exp_data [16];
    logic [31:0] a;
    int r0, w0, lat, n_acc;
    for (int i = 0; i < l; i++) begin
      a = s + 32'(4 * i);
      exp_data[i] = mem[a[11:2]];
    end
    stall_n = st;
    r0 = rd_done;
    w0 = wr_done;
    rd_cyc = 0;
    launch(s, d, l);
    wait_done(lat);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_error"}, {31'b0, error}, {31'b0, exp_err});
    chk({name, "_busy_at_done"}, {31'b0, busy}, 32'h1);
    tick();
    chk({name, "_busy_after"}, {31'b0, busy}, 32'h0);
    chk({name, "_done_pulse"}, {31'b0, done}, 32'h0);
    n_acc = (exp_err || l == 0) ? 0 : l;
    chk({name, "_reads"}, rd_done - r0, n_acc);
    chk({name, "_writes"}, wr_done - w0, n_acc);
    if (n_acc == 0) chk({name, "_no_read_req"}, rd_cyc, 0);
    for (int i = 0; i < n_acc; i++) begin
      a = d + 32'(4 * i);
      chk($sformatf("%s_data%0d", name, i), mem[a[11:2]], exp_data[i]);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          stall;
    bit          err;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, seen, w0;
    logic [31:0] e0, e1, keep;

    vecs[0] = '{"copy3",      32'h100,      32'h200, 3, 0, 1'b0, 13};
    vecs[1] = '{"stall3",     32'h300,      32'h400, 2, 3, 1'b0, 21};
    vecs[2] = '{"mis_src",    32'h102,      32'h500, 2, 0, 1'b1, 1};
    vecs[3] = '{"mis_dst",    32'h100,      32'h501, 1, 0, 1'b1, 1};
    vecs[4] = '{"len0",       32'h100,      32'h500, 0, 0, 1'b0, 1};
    vecs[5] = '{"stall1",     32'h600,      32'h700, 1, 1, 1'b0, 7};
    vecs[6] = '{"copy5",      32'h7F0,      32'hD00, 5, 0, 1'b0, 21};
    vecs[7] = '{"addr_wrap",  32'hFFFF_FFFC, 32'h800, 2, 0, 1'b0, 9};

    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    fill = 1'b1;
    tick();
    fill = 1'b0;
    tick();
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_error", {31'b0, error}, 32'h0);
    chk("rst_req", {30'b0, mem_memread, mem_memwrite}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wr_data, 32'h0);
    reset = 1'b0;

    poke(10'h40, 32'hA);
    poke(10'h41, 32'hB);
    poke(10'h42, 32'hC);

    for (int v = 0; v < 8; v++)
      run(vecs[v].name, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].stall, vecs[v].err, vecs[v].lat);
    chk("copy3_word0_const", mem[10'h80], 32'hA);
    chk("copy3_word2_const", mem[10'h82], 32'hC);

    // Timeout: stall stuck high, 8 stall cycles after the issue cycle.
    stuck = 1'b1;
    stall_n = 0;
    w0 = wr_done;
    rd_cyc = 0;
    launch(32'h100, 32'h200, 1);
    wait_done(lat);
    chk("timeout_latency", lat, 10);
    chk("timeout_error", {31'b0, error}, 32'h1);
    chk("timeout_read_cycles", rd_cyc, 9);
    chk("timeout_writes", wr_done - w0, 0);
    stuck = 1'b0;
    tick();

    // Reset during the second word's write.
    e0 = mem[10'h40];
    keep = mem[10'h241];
    launch(32'h100, 32'h900, 4);
    for (int k = 0; k < 7; k++) tick();
    chk("midrst_in_wr2", {31'b0, mem_memwrite}, 32'h1);
    chk("midrst_wr2_addr", mem_addr, 32'h904);
    reset = 1'b1;
    tick();
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_outs", {29'b0, done, mem_memread, mem_memwrite}, 32'h0);
    chk("midrst_addr", mem_addr, 32'h0);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    chk("midrst_no_done", seen, 0);
    chk("midrst_word0", mem[10'h240], e0);
    chk("midrst_word1_untouched", mem[10'h241], keep);
    run("after_reset", 32'h100, 32'hA00, 4, 0, 1'b0, 17);

    // start pulsed while busy with different operands is ignored.
    e0 = mem[10'h40];
    e1 = mem[10'h41];
    keep = mem[10'h300];
    stall_n = 0;
    launch(32'h100, 32'hB00, 2);
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 3) launch(32'h300, 32'hC00, 5);
    end while (done !== 1'b1 && lat < 2000);
    chk("busy_start_done", {31'b0, done}, 32'h1);
    chk("busy_start_latency", lat, 9);
    chk("busy_start_error", {31'b0, error}, 32'h0);
    tick();
    chk("busy_start_busy_low", {31'b0, busy}, 32'h0);
    chk("busy_start_word0", mem[10'h2C0], e0);
    chk("busy_start_word1", mem[10'h2C1], e1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("busy_start_no_second", seen, 0);
    chk("busy_start_c00_untouched", mem[10'h300], keep);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
